// File: rtl/uart_baud_gen.sv
// UART baud tick generator: integer+fractional divisor producing an oversample strobe and a bit strobe.
// Ticks are registered; divisor updates written while running take effect at the next period boundary.
module uart_baud_gen #(
  parameter int CNT_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int OS_RATE = 16,
  parameter int DEF_DIV = 1001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              resync,
  input  logic              cfg_wr,
  input  logic [CNT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_busy,
  output logic              os_tick,
  output logic              bit_tick
);
  localparam int OS_W = $clog2(OS_RATE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W:0]    cnt, cnt_nxt, eff_int, lim;
  logic [FRAC_W:0]   acc_sum;
  logic [FRAC_W-1:0] acc, acc_nxt;
  logic [OS_W-1:0]   os_cnt, os_cnt_nxt;
  logic [CNT_W-1:0]  act_int, act_int_nxt, sh_int, sh_int_nxt;
  logic [FRAC_W-1:0] act_frac, act_frac_nxt, sh_frac, sh_frac_nxt;
  logic              busy_nxt, os_nxt, bit_nxt, wrap;

  // Divisors below 2 are clamped so the strobe can never be held high continuously.
  assign eff_int = (act_int < CNT_W'(2)) ? (CNT_W+1)'(2) : {1'b0, act_int};
  assign acc_sum = {1'b0, acc} + {1'b0, act_frac};
  assign lim     = eff_int - (CNT_W+1)'(1) + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};
  assign wrap    = (state == RUN) && (cnt == lim);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc;
    os_cnt_nxt   = os_cnt;
    act_int_nxt  = act_int;
    act_frac_nxt = act_frac;
    sh_int_nxt   = sh_int;
    sh_frac_nxt  = sh_frac;
    busy_nxt     = cfg_busy;
    os_nxt       = 1'b0;
    bit_nxt      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        acc_nxt    = '0;
        os_cnt_nxt = '0;
        busy_nxt   = 1'b0;
        if (cfg_wr) begin
          act_int_nxt  = cfg_int;
          act_frac_nxt = cfg_frac;
        end
        if (run) state_nxt = RUN;
      end
      RUN: begin
        if (!run) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          acc_nxt    = '0;
          os_cnt_nxt = '0;
          busy_nxt   = 1'b0;
          if (cfg_wr) begin
            act_int_nxt  = cfg_int;
            act_frac_nxt = cfg_frac;
          end else if (cfg_busy) begin
            act_int_nxt  = sh_int;
            act_frac_nxt = sh_frac;
          end
        end else begin
          if (resync) begin
            // Restart half a bit in so the next bit strobe lands mid-bit.
            cnt_nxt    = '0;
            acc_nxt    = '0;
            os_cnt_nxt = OS_W'(OS_RATE / 2);
          end else if (wrap) begin
            cnt_nxt    = '0;
            acc_nxt    = acc_sum[FRAC_W-1:0];
            os_cnt_nxt = os_cnt + OS_W'(1);
            os_nxt     = 1'b1;
            bit_nxt    = (os_cnt == OS_W'(OS_RATE - 1));
          end else begin
            cnt_nxt = cnt + (CNT_W+1)'(1);
          end
          if ((resync || wrap) && cfg_busy) begin
            act_int_nxt  = sh_int;
            act_frac_nxt = sh_frac;
            busy_nxt     = 1'b0;
          end
          // A write coinciding with a boundary waits for the following one.
          if (cfg_wr) begin
            sh_int_nxt  = cfg_int;
            sh_frac_nxt = cfg_frac;
            busy_nxt    = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      os_cnt   <= '0;
      act_int  <= CNT_W'(DEF_DIV);
      act_frac <= '0;
      sh_int   <= '0;
      sh_frac  <= '0;
      cfg_busy <= 1'b0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      os_cnt   <= os_cnt_nxt;
      act_int  <= act_int_nxt;
      act_frac <= act_frac_nxt;
      sh_int   <= sh_int_nxt;
      sh_frac  <= sh_frac_nxt;
      cfg_busy <= busy_nxt;
      os_tick  <= os_nxt;
      bit_tick <= bit_nxt;
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen (OS_RATE=4): expected tick cycles are queued by a period model and
// matched against observed strobes.
module tb_uart_baud_gen;
  logic        clk = 1'b0;
  logic        rst_n, run, resync, cfg_wr;
  logic [15:0] cfg_int;
  logic [3:0]  cfg_frac;
  logic        cfg_busy, os_tick, bit_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int os_q[$];
  int bit_q[$];

  uart_baud_gen #(.CNT_W(16), .FRAC_W(4), .OS_RATE(4), .DEF_DIV(1001)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .resync(resync), .cfg_wr(cfg_wr),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_busy(cfg_busy),
    .os_tick(os_tick), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (os_tick === 1'b1) begin
      if (os_q.size() == 0) chk("os_unexpected", cyc, -1);
      else chk("os_time", cyc, os_q.pop_front());
    end
    if (bit_tick === 1'b1) begin
      chk("bit_with_os", os_tick, 1);
      if (bit_q.size() == 0) chk("bit_unexpected", cyc, -1);
      else chk("bit_time", cyc, bit_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) step();
  endtask

  // Reference period model: divisor int + frac/16, clamped to >= 2, every 4th strobe is a bit strobe.
  task automatic push_run(input int c0, input int di, input int fr, input int n, output int last);
    int eff, acc, s, t;
    eff = (di < 2) ? 2 : di;
    acc = 0;
    t   = c0 + 1;
    for (int k = 0; k < n; k++) begin
      s   = acc + fr;
      t   = t + eff + ((s >= 16) ? 1 : 0);
      acc = s % 16;
      os_q.push_back(t);
      if (k % 4 == 3) bit_q.push_back(t);
    end
    last = t;
  endtask

  task automatic finish_run();
    run = 1'b0;
    repeat (6) step();
    chk("os_left", os_q.size(), 0);
    chk("bit_left", bit_q.size(), 0);
    os_q.delete();
    bit_q.delete();
  endtask

  task automatic load_cfg(input int di, input int fr);
    cfg_wr   = 1'b1;
    cfg_int  = 16'(di);
    cfg_frac = 4'(fr);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic do_run(input bit wr, input int di, input int fr, input int n);
    int c0, tl;
    if (wr) load_cfg(di, fr);
    run = 1'b1;
    c0  = cyc;
    push_run(c0, wr ? di : 1001, wr ? fr : 0, n, tl);
    tick_to(tl);
    finish_run();
  endtask

  initial begin
    int c0, c1, r;
    rst_n = 1'b0; run = 1'b0; resync = 1'b0; cfg_wr = 1'b0; cfg_int = '0; cfg_frac = '0;
    step(); step();
    chk("rst_busy", cfg_busy, 0);
    chk("rst_os", os_tick, 0);
    chk("rst_bit", bit_tick, 0);
    rst_n = 1'b1;
    step();

    do_run(1'b0, 1001, 0, 5);
    do_run(1'b1, 4, 0, 8);
    do_run(1'b1, 4, 8, 16);
    do_run(1'b1, 0, 0, 6);
    do_run(1'b1, 1, 0, 6);

    // resync landing on a due wrap: that tick is suppressed, bit strobe two strobes later
    load_cfg(4, 0);
    run = 1'b1;
    c0  = cyc;
    os_q.push_back(c0 + 5);
    os_q.push_back(c0 + 9);
    tick_to(c0 + 12);
    resync = 1'b1;
    step();
    resync = 1'b0;
    r = c0 + 13;
    os_q.push_back(r + 4);
    os_q.push_back(r + 8);
    bit_q.push_back(r + 8);
    os_q.push_back(r + 12);
    os_q.push_back(r + 16);
    tick_to(r + 16);
    finish_run();

    // live reconfig: current period keeps the old divisor
    load_cfg(4, 0);
    run = 1'b1;
    c0  = cyc;
    os_q.push_back(c0 + 5);
    os_q.push_back(c0 + 9);
    os_q.push_back(c0 + 15);
    os_q.push_back(c0 + 21);
    bit_q.push_back(c0 + 21);
    os_q.push_back(c0 + 27);
    tick_to(c0 + 6);
    load_cfg(6, 0);
    chk("busy_set", cfg_busy, 1);
    step();
    chk("busy_hold", cfg_busy, 1);
    step();
    chk("busy_clear", cfg_busy, 0);
    tick_to(c0 + 27);
    finish_run();

    // run dropped mid-period, then restarted: first strobe must come a full period later
    load_cfg(4, 0);
    run = 1'b1;
    c0  = cyc;
    os_q.push_back(c0 + 5);
    tick_to(c0 + 6);
    run = 1'b0;
    step();
    step();
    chk("drop_os", os_tick, 0);
    step();
    run = 1'b1;
    c1  = cyc;
    os_q.push_back(c1 + 5);
    os_q.push_back(c1 + 9);
    tick_to(c1 + 9);
    finish_run();

    // reset while a shadow divisor is pending
    load_cfg(4, 0);
    run = 1'b1;
    c0  = cyc;
    os_q.push_back(c0 + 5);
    tick_to(c0 + 6);
    load_cfg(6, 0);
    chk("busy_pre_rst", cfg_busy, 1);
    rst_n = 1'b0;
    run   = 1'b0;
    step();
    step();
    chk("busy_rst", cfg_busy, 0);
    chk("os_rst", os_tick, 0);
    rst_n = 1'b1;
    step();
    chk("os_left_rst", os_q.size(), 0);
    do_run(1'b0, 1001, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
